// File: rtl/dmem_load_if.sv
// Load-unit bus bundle: core-side load request/response plus the
// data-memory read handshake. The load unit uses the slave view.
interface dmem_load_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_signed;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  ld_valid, ld_addr, ld_size, ld_signed, mem_ack, mem_rdata,
    output ld_ready, rd_valid, rd_data, rd_err, mem_req, mem_addr
  );

  modport master (
    output ld_valid, ld_addr, ld_size, ld_signed, mem_ack, mem_rdata,
    input  ld_ready, rd_valid, rd_data, rd_err, mem_req, mem_addr
  );
endinterface

// File: rtl/dmem_load_unit.sv
// Data-memory load unit: accepts one load at a time, issues a word-aligned
// memory read, extracts and extends the addressed byte/halfword/word, and
// returns it with a one-cycle strobe. Misaligned/illegal requests and
// unacknowledged reads return an error response instead of hanging.
module dmem_load_unit #(
  parameter int TIMEOUT = 16
) (
  input logic        clk,
  input logic        reset,
  dmem_load_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  lane;
  logic [1:0]  size;
  logic        sgn;
  logic [7:0]  cnt;
  logic [31:0] mem_addr_r;
  logic [31:0] rd_data_r;
  logic        rd_err_r;
  logic        xfer;
  logic        misaligned;
  logic        timed_out;

  // Select the addressed lane (little-endian) and sign/zero-extend it.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  ln,
                                              input logic [1:0]  sz,
                                              input logic        sg);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
    b = word[{ln, 3'b000} +: 8];
    h = ln[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   res = sg ? 32'(b) : {24'd0, b};
      2'b01:   res = sg ? 32'(h) : {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  assign xfer       = bus.ld_valid && (state == IDLE);
  assign misaligned = (bus.ld_size == 2'b11) ||
                      ((bus.ld_size == 2'b01) && bus.ld_addr[0]) ||
                      ((bus.ld_size == 2'b10) && (bus.ld_addr[1:0] != 2'b00));
  assign timed_out  = (cnt == 8'(TIMEOUT - 1));

  assign bus.ld_ready = (state == IDLE);
  assign bus.mem_req  = (state == REQ);
  assign bus.rd_valid = (state == RESP);
  assign bus.mem_addr = mem_addr_r;
  assign bus.rd_data  = rd_data_r;
  assign bus.rd_err   = rd_err_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: ack wins over timeout; misaligned requests skip memory.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (xfer) state_nxt = misaligned ? RESP : REQ;
      REQ:  if (bus.mem_ack || timed_out) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields needed after acceptance for lane extraction.
  always_ff @(posedge clk) begin
    if (xfer) begin
      lane <= bus.ld_addr[1:0];
      size <= bus.ld_size;
      sgn  <= bus.ld_signed;
    end
  end

  // Memory address, wait counter and the held response data/error.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_r <= 32'd0;
      rd_data_r  <= 32'd0;
      rd_err_r   <= 1'b0;
      cnt        <= 8'd0;
    end else begin
      if (xfer) begin
        cnt <= 8'd0;
        if (misaligned) begin
          rd_data_r <= 32'd0;
          rd_err_r  <= 1'b1;
        end else begin
          mem_addr_r <= {bus.ld_addr[31:2], 2'b00};
        end
      end else if (state == REQ) begin
        if (bus.mem_ack) begin
          rd_data_r <= extend_load(bus.mem_rdata, lane, size, sgn);
          rd_err_r  <= 1'b0;
        end else if (timed_out) begin
          rd_data_r <= 32'd0;
          rd_err_r  <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_load_unit.sv
// Self-checking bench for dmem_load_unit with a behavioural load model.
module tb_dmem_load_unit;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  dmem_load_if bus();

  dmem_load_unit #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {err, data} from the architectural load rules.
  function automatic logic [32:0] model(input logic [31:0] addr, input logic [1:0] sz,
                                        input logic sg, input logic [31:0] w);
    longint      v;
    int unsigned sh;
    if (sz == 2'd3 || (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0))
      return {1'b1, 32'h0};
    sh = 32'(addr % 4) * 8;
    v  = longint'(w >> sh);
    if (sz == 2'd0) begin
      v = v % 256;
      if (sg && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (sg && v >= 32768) v = v - 65536;
    end
    return {1'b0, v[31:0]};
  endfunction

  task automatic run_load(input logic [31:0] addr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] w, input int delay,
                          output int req_cyc, output int lat, output int nvalid,
                          output int ready_busy, output logic [31:0] data,
                          output logic err, output logic [31:0] maddr);
    int waited;
    req_cyc = 0; lat = 0; nvalid = 0; ready_busy = 0;
    data = 32'h0; err = 1'b0; maddr = 32'h0; waited = 0;
    @(negedge clk);
    bus.ld_valid = 1'b1; bus.ld_addr = addr; bus.ld_size = sz; bus.ld_signed = sg;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.ld_ready && (bus.mem_req || bus.rd_valid)) ready_busy++;
      if (bus.mem_req) begin
        req_cyc++;
        maddr = bus.mem_addr;
        if (delay >= 0 && waited == delay) begin
          bus.mem_ack = 1'b1; bus.mem_rdata = w;
        end else begin
          bus.mem_rdata = $urandom;
        end
        waited++;
      end
      if (bus.rd_valid) begin
        nvalid++;
        if (lat == 0) lat = c;
        data = bus.rd_data; err = bus.rd_err;
      end
      if (lat != 0 && c >= lat + 2) break;
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.ld_ready !== 1'b1) begin bad++; $display("FAIL reset_ld_ready got=%b want=1", bus.ld_ready); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", bus.rd_valid); end
    total++; if (bus.rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", bus.rd_data); end
    total++; if (bus.rd_err !== 1'b0) begin bad++; $display("FAIL reset_rd_err got=%b want=0", bus.rd_err); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b want=0", bus.mem_req); end
    total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", bus.mem_addr); end
    reset = 1'b0;
  endtask

  task automatic test_word();
    int rq, lt, nv, rb; logic [31:0] d, ma; logic e;
    run_load(32'h100, 2'd2, 1'b0, 32'hDEADBEEF, 0, rq, lt, nv, rb, d, e, ma);
    total++; if (ma !== 32'h100) begin bad++; $display("FAIL word_mem_addr got=%h want=100", ma); end
    total++; if (lt !== 2) begin bad++; $display("FAIL word_latency got=%0d want=2", lt); end
    total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL word_data got=%h want=deadbeef", d); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL word_err got=%b want=0", e); end
    total++; if (nv !== 1) begin bad++; $display("FAIL word_strobes got=%0d want=1", nv); end
  endtask

  task automatic test_byte();
    int rq, lt, nv, rb; logic [31:0] d, ma; logic e;
    run_load(32'h103, 2'd0, 1'b1, 32'h80112233, 0, rq, lt, nv, rb, d, e, ma);
    total++; if (d !== 32'hFFFFFF80) begin bad++; $display("FAIL byte_signed got=%h want=ffffff80", d); end
    run_load(32'h103, 2'd0, 1'b0, 32'h80112233, 0, rq, lt, nv, rb, d, e, ma);
    total++; if (d !== 32'h00000080) begin bad++; $display("FAIL byte_unsigned got=%h want=00000080", d); end
    run_load(32'h101, 2'd0, 1'b1, 32'h80112233, 0, rq, lt, nv, rb, d, e, ma);
    total++; if (d !== 32'h00000022) begin bad++; $display("FAIL byte_lane1 got=%h want=00000022", d); end
    total++; if (ma !== 32'h100) begin bad++; $display("FAIL byte_mem_addr got=%h want=100", ma); end
  endtask

  task automatic test_half();
    int rq, lt, nv, rb; logic [31:0] d, ma; logic e;
    run_load(32'h202, 2'd1, 1'b1, 32'h9ABC1234, 0, rq, lt, nv, rb, d, e, ma);
    total++; if (d !== 32'hFFFF9ABC) begin bad++; $display("FAIL half_data got=%h want=ffff9abc", d); end
    total++; if (ma !== 32'h200) begin bad++; $display("FAIL half_mem_addr got=%h want=200", ma); end
    run_load(32'h201, 2'd1, 1'b1, 32'h9ABC1234, 0, rq, lt, nv, rb, d, e, ma);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL half_misaligned_err got=%b want=1", e); end
    total++; if (d !== 32'h0) begin bad++; $display("FAIL half_misaligned_data got=%h want=0", d); end
    total++; if (rq !== 0) begin bad++; $display("FAIL half_misaligned_req got=%0d want=0", rq); end
    total++; if (nv !== 1) begin bad++; $display("FAIL half_misaligned_strobes got=%0d want=1", nv); end
  endtask

  task automatic test_ack_delay();
    int rq, lt, nv, rb; logic [31:0] d, ma; logic e;
    run_load(32'h40, 2'd2, 1'b0, 32'h13572468, 5, rq, lt, nv, rb, d, e, ma);
    total++; if (rq !== 6) begin bad++; $display("FAIL delay_req_cycles got=%0d want=6", rq); end
    total++; if (rb !== 0) begin bad++; $display("FAIL delay_ready_busy got=%0d want=0", rb); end
    total++; if (nv !== 1) begin bad++; $display("FAIL delay_strobes got=%0d want=1", nv); end
    total++; if (lt !== 7) begin bad++; $display("FAIL delay_latency got=%0d want=7", lt); end
    total++; if (d !== 32'h13572468) begin bad++; $display("FAIL delay_data got=%h want=13572468", d); end
    run_load(32'h44, 2'd2, 1'b0, 32'h11111111, -1, rq, lt, nv, rb, d, e, ma);
    total++; if (rq !== 16) begin bad++; $display("FAIL timeout_req_cycles got=%0d want=16", rq); end
    total++; if (nv !== 1) begin bad++; $display("FAIL timeout_strobes got=%0d want=1", nv); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b want=1", e); end
    total++; if (d !== 32'h0) begin bad++; $display("FAIL timeout_data got=%h want=0", d); end
  endtask

  task automatic test_random();
    int rq, lt, nv, rb, dl; logic [31:0] d, ma, a, w; logic e, sg; logic [1:0] sz;
    logic [32:0] ex;
    for (int i = 0; i < 30; i++) begin
      a  = $urandom;
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom);
      w  = $urandom;
      dl = $urandom_range(0, 3);
      ex = model(a, sz, sg, w);
      run_load(a, sz, sg, w, dl, rq, lt, nv, rb, d, e, ma);
      total++; if (e !== ex[32] || d !== ex[31:0]) begin
        bad++; $display("FAIL rand_result i=%0d got=%b/%h want=%b/%h", i, e, d, ex[32], ex[31:0]);
      end
      total++; if (nv !== 1 || lt !== (ex[32] ? 1 : dl + 2)) begin
        bad++; $display("FAIL rand_timing i=%0d got=%0d strobes lat %0d want=1 lat %0d", i, nv, lt, ex[32] ? 1 : dl + 2);
      end
      total++; if (rq !== (ex[32] ? 0 : dl + 1)) begin
        bad++; $display("FAIL rand_req_cycles i=%0d got=%0d want=%0d", i, rq, ex[32] ? 0 : dl + 1);
      end
      if (!ex[32]) begin
        total++; if (ma !== {a[31:2], 2'b00}) begin
          bad++; $display("FAIL rand_mem_addr i=%0d got=%h want=%h", i, ma, {a[31:2], 2'b00});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a[3];
    logic [31:0] wd[3];
    logic [31:0] got[$];
    int          acc[$];
    int          k, inflight, overlap;
    logic [32:0] ex;
    a = '{32'h300, 32'h304, 32'h308};
    for (int i = 0; i < 3; i++) wd[i] = $urandom;
    k = 0; inflight = 0; overlap = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = wd[inflight];
      end else if (bus.ld_ready) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
      end
      if (bus.ld_ready && (bus.mem_req || bus.rd_valid)) overlap++;
      if (bus.rd_valid) got.push_back(bus.rd_data);
      if (k < 3) begin
        bus.ld_valid = 1'b1; bus.ld_addr = a[k]; bus.ld_size = 2'd2; bus.ld_signed = 1'($urandom);
      end else begin
        bus.ld_valid = 1'b0;
      end
      if (bus.ld_ready && k < 3) begin
        acc.push_back(c); inflight = k; k++;
      end
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    total++; if (got.size() !== 3) begin bad++; $display("FAIL b2b_strobes got=%0d want=3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      ex = model(a[i], 2'd2, 1'b0, wd[i]);
      total++; if (i >= got.size() || got[i] !== ex[31:0]) begin
        bad++; $display("FAIL b2b_data i=%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 32'h0, ex[31:0]);
      end
    end
    total++; if (acc.size() !== 3 || acc[0] !== 0 || acc[1] !== 3 || acc[2] !== 6) begin
      bad++; $display("FAIL b2b_accept_cycles got=%0d accepts want=3 at 0,3,6", acc.size());
    end
    total++; if (overlap !== 0) begin bad++; $display("FAIL b2b_ready_busy got=%0d want=0", overlap); end
  endtask

  task automatic test_reset_mid();
    int nv, rq;
    @(negedge clk);
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h500; bus.ld_size = 2'd2; bus.ld_signed = 1'b0;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rstmid_mem_req got=%b want=0", bus.mem_req); end
    total++; if (bus.ld_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ld_ready got=%b want=1", bus.ld_ready); end
    total++; if (bus.rd_data !== 32'h0) begin bad++; $display("FAIL rstmid_rd_data got=%h want=0", bus.rd_data); end
    reset = 1'b0;
    nv = 0; rq = 0;
    if (bus.rd_valid) nv++;
    for (int c = 0; c < 20; c++) begin
      bus.mem_ack = (c < 3); bus.mem_rdata = $urandom;
      @(negedge clk);
      if (bus.rd_valid) nv++;
      if (bus.mem_req) rq++;
    end
    bus.mem_ack = 1'b0;
    total++; if (nv !== 0) begin bad++; $display("FAIL rstmid_rd_valid got=%0d want=0", nv); end
    total++; if (rq !== 0) begin bad++; $display("FAIL rstmid_req_after got=%0d want=0", rq); end
  endtask

  initial begin
    reset = 1'b1;
    bus.ld_valid = 1'b0; bus.ld_addr = 32'h0; bus.ld_size = 2'd0; bus.ld_signed = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_ack_delay();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
